// File: rtl/rv_plic_src_gateway.sv
// Per-source PLIC interrupt gateway: level/edge capture with claim/complete handshake.
// Define RV_PLIC_GW_EDGE_CNT_EN to replace the 1-bit edge latch with a saturating edge counter.
module rv_plic_src_gateway #(
   parameter int unsigned N_SOURCE   = 32,
   parameter int unsigned EDGE_CNT_W = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [N_SOURCE-1:0] src_i,
   input  logic [N_SOURCE-1:0] le_i,
   input  logic [N_SOURCE-1:0] claim_i,
   input  logic [N_SOURCE-1:0] complete_i,
   output logic [N_SOURCE-1:0] ip_o,
   output logic [N_SOURCE-1:0] active_o
);

   typedef enum logic [1:0] {IDLE, PEND, ACTIVE} gw_state_e;

   if (N_SOURCE < 2 || EDGE_CNT_W < 1) begin : g_bad_param
      $error("rv_plic_src_gateway: N_SOURCE must be >= 2 and EDGE_CNT_W >= 1");
   end

   gw_state_e           state_q [N_SOURCE];
   gw_state_e           state_d [N_SOURCE];
   logic [N_SOURCE-1:0] src_q;
   logic [N_SOURCE-1:0] rise;

   assign rise = src_i & ~src_q;

`ifdef RV_PLIC_GW_EDGE_CNT_EN
   logic [EDGE_CNT_W-1:0] cnt_q [N_SOURCE];
   logic [EDGE_CNT_W-1:0] cnt_d [N_SOURCE];
   logic [N_SOURCE-1:0]   pending_edge;

   always_comb begin
      for (int unsigned i = 0; i < N_SOURCE; i++) begin
         pending_edge[i] = (cnt_q[i] != '0) | rise[i];
      end
   end
`else
   logic [N_SOURCE-1:0] edge_q;
   logic [N_SOURCE-1:0] edge_d;
   logic [N_SOURCE-1:0] pending_edge;

   assign pending_edge = edge_q | rise;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_q <= '0;
         for (int unsigned i = 0; i < N_SOURCE; i++) begin
            state_q[i] <= IDLE;
`ifdef RV_PLIC_GW_EDGE_CNT_EN
            cnt_q[i]   <= '0;
`endif
         end
`ifndef RV_PLIC_GW_EDGE_CNT_EN
         edge_q <= '0;
`endif
      end else begin
         src_q <= src_i;
         for (int unsigned i = 0; i < N_SOURCE; i++) begin
            state_q[i] <= state_d[i];
`ifdef RV_PLIC_GW_EDGE_CNT_EN
            cnt_q[i]   <= cnt_d[i];
`endif
         end
`ifndef RV_PLIC_GW_EDGE_CNT_EN
         edge_q <= edge_d;
`endif
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < N_SOURCE; i++) begin
         state_d[i] = state_q[i];
         unique case (state_q[i])
            IDLE:   if (le_i[i] ? rise[i] : src_i[i]) state_d[i] = PEND;
            PEND:   if (claim_i[i]) state_d[i] = ACTIVE;
            ACTIVE: if (complete_i[i]) begin
               state_d[i] = (le_i[i] ? pending_edge[i] : src_i[i]) ? PEND : IDLE;
            end
            default: state_d[i] = IDLE;
         endcase
      end
   end

`ifdef RV_PLIC_GW_EDGE_CNT_EN
   // A rise coinciding with the re-pend on complete cancels out: count unchanged.
   always_comb begin
      for (int unsigned i = 0; i < N_SOURCE; i++) begin
         cnt_d[i] = cnt_q[i];
         if (!le_i[i]) begin
            cnt_d[i] = '0;
         end else begin
            unique case ({rise[i] && state_q[i] != IDLE,
                          state_q[i] == ACTIVE && complete_i[i] && pending_edge[i]})
               2'b10:   if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
               2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
               default: cnt_d[i] = cnt_q[i];
            endcase
         end
      end
   end
`else
   always_comb begin
      edge_d = edge_q;
      for (int unsigned i = 0; i < N_SOURCE; i++) begin
         if (!le_i[i]) begin
            edge_d[i] = 1'b0;
         end else if (state_q[i] == ACTIVE) begin
            if (complete_i[i]) edge_d[i] = 1'b0;
            else if (rise[i])  edge_d[i] = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      for (int unsigned i = 0; i < N_SOURCE; i++) begin
         ip_o[i]     = (state_q[i] == PEND);
         active_o[i] = (state_q[i] == ACTIVE);
      end
   end

endmodule

// File: tb/tb_rv_plic_src_gateway.sv
// Self-checking bench for rv_plic_src_gateway: directed protocol scenarios plus randomized
// traffic, every cycle compared against a per-source behavioural model.
module tb_rv_plic_src_gateway;

   localparam int unsigned NS   = 32;
   localparam int unsigned CW   = 4;
   localparam int          MAXC = (1 << CW) - 1;
`ifdef RV_PLIC_GW_EDGE_CNT_EN
   localparam bit CNT_MODE = 1'b1;
`else
   localparam bit CNT_MODE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [NS-1:0] src, le, claim, complete;
   logic [NS-1:0] ip_o, active_o;

   int n_cmp = 0;
   int n_err = 0;

   // Model: per source, pending/claimed flags, previous src, and number of remembered edges.
   bit m_pend [NS];
   bit m_act  [NS];
   bit m_sq   [NS];
   int m_lat  [NS];

   rv_plic_src_gateway #(.N_SOURCE(NS), .EDGE_CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst), .src_i(src), .le_i(le), .claim_i(claim),
      .complete_i(complete), .ip_o(ip_o), .active_o(active_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [NS-1:0] obs, input logic [NS-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < NS; i++) begin
         bit s, l, r;
         s = src[i]; l = le[i]; r = s && !m_sq[i];
         if (rst) begin
            m_pend[i] = 0; m_act[i] = 0; m_sq[i] = 0; m_lat[i] = 0;
         end else begin
            if (m_act[i]) begin
               if (complete[i]) begin
                  bit again;
                  again = l ? (m_lat[i] > 0 || r) : s;
                  m_act[i] = 0; m_pend[i] = again;
                  if (CNT_MODE && l) m_lat[i] = m_lat[i] + int'(r) - int'(again);
                  else m_lat[i] = 0;
               end else if (l && r) begin
                  m_lat[i] = CNT_MODE ? ((m_lat[i] < MAXC) ? m_lat[i] + 1 : MAXC) : 1;
               end
            end else if (m_pend[i]) begin
               if (CNT_MODE && l && r && m_lat[i] < MAXC) m_lat[i]++;
               if (claim[i]) begin m_pend[i] = 0; m_act[i] = 1; end
            end else if (l ? r : s) begin
               m_pend[i] = 1;
            end
            if (!l) m_lat[i] = 0;
            m_sq[i] = s;
         end
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         logic [NS-1:0] eip, eact;
         model_step();
         @(posedge clk);
         #1;
         for (int i = 0; i < NS; i++) begin eip[i] = m_pend[i]; eact[i] = m_act[i]; end
         chk("ip_cycle", ip_o, eip);
         chk("active_cycle", active_o, eact);
      end
   endtask

   task automatic pulse5();
      src[5] = 1'b1; tick(1); src[5] = 1'b0; tick(1);
   endtask

   // Claim/complete rounds on source 5 until it stops re-pending; returns re-pend count.
   task automatic drain5(output int repends);
      repends = 0;
      for (int r = 0; r < 40; r++) begin
         claim[5] = 1'b1; tick(1); claim[5] = 1'b0;
         complete[5] = 1'b1; tick(1); complete[5] = 1'b0;
         if (ip_o[5] !== 1'b1) break;
         repends++;
      end
   endtask

   initial begin
      int rp;
      rst = 1'b1; src = '0; le = '0; claim = '0; complete = '0;
      tick(2);
      chk("reset_ip", ip_o, '0);
      chk("reset_active", active_o, '0);
      rst = 1'b0;

      // Level mode, source 3
      src[3] = 1'b1; tick(1);
      chk("lvl_pend", 32'(ip_o[3]), 32'd1);
      tick(3);
      claim[3] = 1'b1; tick(1); claim[3] = 1'b0;
      chk("lvl_claim", 32'({ip_o[3], active_o[3]}), 32'b01);
      tick(2);
      complete[3] = 1'b1; tick(1); complete[3] = 1'b0;
      chk("lvl_repend", 32'({ip_o[3], active_o[3]}), 32'b10);
      claim[3] = 1'b1; tick(1); claim[3] = 1'b0;
      src[3] = 1'b0; tick(1);
      complete[3] = 1'b1; tick(1); complete[3] = 1'b0;
      chk("lvl_idle", 32'({ip_o[3], active_o[3]}), 32'b00);

      // Edge mode, source 5: pend held; second pulse in PEND
      le[5] = 1'b1;
      pulse5();
      chk("edge_pend", 32'(ip_o[5]), 32'd1);
      tick(3);
      chk("edge_hold", 32'(ip_o[5]), 32'd1);
      pulse5();
      drain5(rp);
      chk("edge_pend_pulse_repends", rp, CNT_MODE ? 1 : 0);

      // Edge mode, 3 pulses while ACTIVE
      pulse5();
      claim[5] = 1'b1; tick(1); claim[5] = 1'b0;
      for (int k = 0; k < 3; k++) pulse5();
      complete[5] = 1'b1; tick(1); complete[5] = 1'b0;
      chk("edge_active_repend", 32'(ip_o[5]), 32'd1);
      drain5(rp);
      chk("edge_3pulse_repends", rp, CNT_MODE ? 2 : 0);

      // 20 pulses while ACTIVE: counter saturates
      pulse5();
      claim[5] = 1'b1; tick(1); claim[5] = 1'b0;
      for (int k = 0; k < 20; k++) pulse5();
      complete[5] = 1'b1; tick(1); complete[5] = 1'b0;
      drain5(rp);
      chk("edge_sat_repends", rp + 1, CNT_MODE ? MAXC : 1);

      // Protocol errors on source 7 (level mode)
      claim[7] = 1'b1; tick(1); claim[7] = 1'b0;
      chk("claim_idle", 32'({ip_o[7], active_o[7]}), 32'b00);
      src[7] = 1'b1; tick(1); src[7] = 1'b0;
      complete[7] = 1'b1; tick(1); complete[7] = 1'b0;
      chk("complete_pend", 32'({ip_o[7], active_o[7]}), 32'b10);
      claim[7] = 1'b1; complete[7] = 1'b1; tick(1); claim[7] = 1'b0; complete[7] = 1'b0;
      chk("claim_complete_pend", 32'({ip_o[7], active_o[7]}), 32'b01);
      complete[7] = 1'b1; tick(1); complete[7] = 1'b0;
      chk("complete_to_idle", 32'({ip_o[7], active_o[7]}), 32'b00);

      // Reset mid-operation
      src[0] = 1'b1; tick(1); src[0] = 1'b0;
      le[1] = 1'b1; src[1] = 1'b1; tick(1); src[1] = 1'b0; tick(1);
      claim[1] = 1'b1; tick(1); claim[1] = 1'b0;
      src[1] = 1'b1; tick(1); src[1] = 1'b0;
      chk("pre_reset", 32'({ip_o[0], active_o[1], ip_o[2]}), 32'b110);
      le[4] = 1'b1; src[4] = 1'b1;
      rst = 1'b1; tick(1);
      chk("midreset_ip", ip_o, '0);
      chk("midreset_active", active_o, '0);
      rst = 1'b0; tick(1);
      chk("edge_high_at_release", 32'(ip_o[4]), 32'd1);
      complete[1] = 1'b1; tick(1); complete[1] = 1'b0;
      chk("no_repend_after_reset", 32'({ip_o[1], active_o[1]}), 32'b00);
      src[4] = 1'b0;

      // Randomized traffic on all sources
      for (int c = 0; c < 3000; c++) begin
         if (c % 97 == 0) le = $urandom;
         src      = $urandom;
         claim    = $urandom & $urandom;
         complete = $urandom & $urandom;
         rst      = ($urandom_range(0, 299) == 0);
         tick(1);
      end
      rst = 1'b0; src = '0; claim = '0; complete = '0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
